// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: streams the index of every set bit of a captured
// vector, lowest first, one beat per output handshake.
module bit_scan_encoder #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] Z,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] A,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last,
  output logic         empty
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   w_pending_nxt;
  logic           r_empty;
  logic           w_empty_nxt;
  logic [W-1:0]   w_idx;
  logic           w_one_left;
  logic           w_scan;

  assign w_scan = (r_state == SCAN);

  // Descending loop so the lowest set bit wins.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = W'(i);
    end
  end

  assign w_one_left =
    ((r_pending & (r_pending - N'(1))) == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_empty_nxt   = r_empty;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_pending_nxt = Z;
          w_empty_nxt   = (Z == '0);
          w_state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          w_pending_nxt =
            r_pending & (r_pending - N'(1));
          if (w_one_left) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_empty   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_empty   <= w_empty_nxt;
    end
  end

  // Beat outputs are masked outside SCAN so IDLE shows all zeros.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = w_scan;
  assign A         = w_scan ? w_idx : '0;
  assign last      = w_scan && w_one_left;
  assign empty     = w_scan && r_empty;

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Bench for bit_scan_encoder: table vectors, corner sequences and
// random vectors against a queue-based reference of set-bit indices.
module tb_bit_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] Z;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  A;
  logic        out_valid;
  logic        out_ready;
  logic        last;
  logic        empty;

  int checks;
  int errors;

  bit_scan_encoder #(.N(32), .W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Z         (Z),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    bit          bp;
    int          nb;
    int          fa;
    int          la;
    bit          emp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] z);
    chk("send_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    Z        = z;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Model: expected beats are the indices of set bits in ascending
  // order, or a single empty beat at index 0 for a zero vector.
  task automatic collect(input logic [31:0] z,
                         input bit bp,
                         input bit busy,
                         output int nb,
                         output int fa,
                         output int la,
                         output bit emp);
    int q[$];
    bit zero;
    bit exp_last;
    int budget;
    for (int i = 0; i < 32; i++)
      if (((z >> i) & 32'd1) == 32'd1) q.push_back(i);
    zero = (q.size() == 0);
    if (zero) q.push_back(0);
    nb = 0; fa = -1; la = -1; emp = 1'b0;
    budget = 0;
    while (q.size() > 0 && budget < 400) begin
      budget++;
      if (busy) begin
        in_valid = 1'b1;
        Z        = 32'h1;
      end
      chk("scan_vr", {62'd0, out_valid, in_ready}, 64'd2);
      exp_last = (q.size() == 1);
      chk("beat", {57'd0, A, last, empty},
          {57'd0, 5'(q[0]), exp_last, zero});
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        if (nb == 0) fa = int'(A);
        la  = int'(A);
        emp = empty;
        nb++;
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL timeout beats_left=%0d want=0", q.size());
    end
    out_ready = 1'b0;
    chk("idle_vr", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  int nb, fa, la;
  bit emp;
  logic [31:0] rz;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Z         = '0;

    tbl[0] = '{32'h8000_0005, 1'b0, 3, 0, 31, 1'b0};
    tbl[1] = '{32'h0000_0000, 1'b0, 1, 0, 0, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 1'b1, 32, 0, 31, 1'b0};
    tbl[3] = '{32'h0000_0030, 1'b1, 2, 4, 5, 1'b0};
    tbl[4] = '{32'h8000_0000, 1'b0, 1, 31, 31, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_outs",
        {55'd0, in_ready, out_valid, A, last, empty}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vr", {62'd0, out_valid, in_ready}, 64'd1);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].z);
      collect(tbl[i].z, tbl[i].bp, 1'b0, nb, fa, la, emp);
      chk("tbl_nb", 64'(nb), 64'(tbl[i].nb));
      chk("tbl_first", 64'(fa), 64'(tbl[i].fa));
      chk("tbl_lastidx", 64'(la), 64'(tbl[i].la));
      chk("tbl_empty", 64'(emp), 64'(tbl[i].emp));
    end

    // Decoder in front: Z = 1 << a must come back as A = a.
    for (int a = 0; a < 32; a++) begin
      rz = 32'd1 << a;
      send(rz);
      collect(rz, 1'b0, 1'b0, nb, fa, la, emp);
      chk("onehot", {nb == 1, emp, 32'(fa)},
          {1'b1, 1'b0, 32'(a)});
    end

    // Busy input: Z=1 held during the scan of 0x30.
    send(32'h0000_0030);
    collect(32'h0000_0030, 1'b0, 1'b1, nb, fa, la, emp);
    chk("busy_beats", {32'(nb), 16'(fa), 16'(la)},
        {32'd2, 16'd4, 16'd5});
    @(negedge clk);
    in_valid = 1'b0;
    collect(32'h1, 1'b0, 1'b0, nb, fa, la, emp);
    chk("busy_next", {32'(nb), 32'(fa)}, {32'd1, 32'd0});

    // Reset mid-scan after beats 4 and 5 of 0xF0.
    send(32'h0000_00F0);
    chk("rs_a4", {59'd0, A}, 64'd4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rs_a5", {59'd0, A}, 64'd5);
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("rs_in_rst",
        {55'd0, in_ready, out_valid, A, last, empty}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_after", {62'd0, out_valid, in_ready}, 64'd1);
    send(32'h2);
    collect(32'h2, 1'b0, 1'b0, nb, fa, la, emp);
    chk("rs_next", {32'(nb), 32'(fa)}, {32'd1, 32'd1});

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: rz = $urandom & $urandom & $urandom;
        1: rz = 32'd1 << $urandom_range(0, 31);
        2: rz = (t % 5 == 0) ? 32'd0 : $urandom;
        default: rz = $urandom;
      endcase
      send(rz);
      collect(rz, 1'b1, 1'b0, nb, fa, la, emp);
      chk("rand_nb", 64'(nb),
          64'((rz == 0) ? 1 : $countones(rz)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_scan_encoder.md
# bit_scan_encoder

Streaming 32-to-5 encoder: the inverse of the 5-to-32 one-hot `decoder`. It accepts a 32-bit vector `Z` with a valid/ready handshake. It then emits the index `A` of every set bit, lowest index first, one beat per accepted output. A one-hot `Z` yields exactly the `A` that produced it through `decoder`, so the two blocks form a round-trip pair for bench and datapath use. It sits after any block that produces bit-vector request masks and feeds index-based consumers.

## Interface
Parameters:
- `N`, 32: width of input vector `Z`.
- `W`, 5: index width, fixed as clog2(`N`); `N` must be a power of two ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `Z`  in  N  input bit vector; sampled only on an input handshake.
- `in_valid`  in  1  `Z` is valid.
- `in_ready`  out  1  block can accept `Z`; equals (state==IDLE) && `rst_n`.
- `A`  out  W  index of the lowest set bit still pending.
- `out_valid`  out  1  `A`, `last` and `empty` are valid.
- `out_ready`  in  1  consumer accepts the current beat.
- `last`  out  1  current beat is the final beat for this vector.
- `empty`  out  1  the captured vector was all-zero; this is the only beat for it.

## Operation
- Internal state: FSM {IDLE, SCAN} and an N-bit `pending` register.
- Input handshake is (`in_valid` && `in_ready`). Output handshake is (`out_valid` && `out_ready`).
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On an input handshake: `pending` ← `Z`, `empty` flag ← (`Z`==0), next state SCAN.
  - `in_valid` without a handshake has no effect.
- SCAN:
  - `out_valid`=1 and `in_ready`=0. `in_valid` is ignored and `Z` is not sampled.
  - `A` = index of the lowest set bit of `pending`; `A`=0 when `pending`==0.
  - `last` = 1 when `pending` has ≤1 bit set.
  - `empty` = 1 only when the captured vector was 0.
- On an output handshake in SCAN:
  - `pending` ← `pending` & (`pending` − 1), which clears the lowest set bit.
  - If `last`=1, next state is IDLE; otherwise the state stays SCAN.
- No output handshake in SCAN: `A`, `last`, `empty` and `pending` hold unchanged; `out_valid` stays 1.
- A vector with k set bits produces exactly k beats, in strictly ascending `A`. An all-zero vector produces exactly one beat with `A`=0, `last`=1, `empty`=1.
- `A`, `last` and `empty` are functions of registered state only. They are not combinational from `Z`, `in_valid` or `out_ready`.
- Reset: while `rst_n`=0 at an edge, next state is IDLE, `pending`=0 and the `empty` flag=0. Reset has priority over every handshake.
- Reset values of all outputs: `out_valid`=0, `A`=0, `last`=0, `empty`=0. `in_ready`=0 while `rst_n`=0 and 1 in the first cycle after release.
- Reset during SCAN abandons the current vector: no further beats are emitted for it.

## Timing
- Input accepted at edge k → `out_valid`=1 with the first beat in the cycle after edge k (1-cycle latency).
- Beats issue back-to-back at 1 per cycle while `out_ready`=1.
- Final beat accepted at edge m → IDLE after edge m, with `in_ready`=1 in the following cycle. The next vector is accepted at edge m+1 at the earliest.
- Throughput: a vector with k set bits occupies k+1 cycles (max(k,1)+1 for k=0). There is no overlap between vectors.
- The input handshake and the output handshake can never coincide, because `in_ready` and `out_valid` are mutually exclusive.
- `last` rises on the same cycle as the final beat, never earlier.

## Test plan
- One-hot walk: for i=0..31 apply `Z`=1<<i with `out_ready`=1 → exactly one beat, `A`=i, `last`=1, `empty`=0, then `in_ready`=1 the next cycle. Repeat with `decoder` chained in front, `A` swept 0..31 → the encoder's `A` equals the decoder's input.
- Sparse vector: `Z`=32'h8000_0005, `out_ready`=1 → beats on consecutive cycles with `A`=0, 2, 31; `last`=0, 0, 1; 3 beats total.
- Zero vector: `Z`=32'h0 → one beat with `A`=0, `last`=1, `empty`=1, then IDLE.
- Backpressure: `Z`=32'hFFFF_FFFF with `out_ready` toggled pseudo-randomly → 32 accepted beats with `A`=0..31 in order. `A` is stable during every stall, and `last` is set only at `A`=31.
- Busy input: assert `in_valid` with `Z`=32'h1 throughout the SCAN of `Z`=32'h0000_0030 → `in_ready`=0 during SCAN, and the beats are `A`=4, 5. `Z`=32'h1 is accepted only after IDLE is re-entered, giving beat `A`=0.
- Reset mid-scan: `Z`=32'h0000_00F0, hold `rst_n`=0 for one edge after 2 beats (`A`=4, 5) → `out_valid`=0 and `in_ready`=0 while in reset, then `in_ready`=1. No beats `A`=6 or 7 appear. The following `Z`=32'h2 yields a single beat `A`=1 with `last`=1.
